// File: rtl/pcs_rx_link_ctrl.sv
// ----------------------------------------------------------------------------
// pcs_rx_link_ctrl
//
// Receive-side link controller between the PMA and the PCS receive path.
// Conditions the raw PMA signal detect toward the code-group sync block and
// watches its sync status. Once sync is held, the link is qualified by a run
// of even-aligned K28.5 code groups followed by a link timer. Only then is
// SUDI passed downstream. On loss of sync the link is dropped, the event is
// counted, and the controller holds off before it resequences.
//
// Optional build macro:
//   LINK_LOSS_CNT_EN : when defined, a saturating link-loss counter is built.
//                      When undefined, link_loss_cnt is tied to zero.
//
// Ports:
//   clock             in   single clock, all state on rising edge
//   mr_main_reset     in   asynchronous active-low reset
//   signal_detect_in  in   raw PMA signal detect
//   mr_loopback       in   loopback mode, forces signal present
//   mr_restart        in   management restart request (level)
//   code_sync_status  in   1 = sync block is synchronized
//   rx_even           in   1 = current code group is in even position
//   sudi_in[9:0]      in   code group from sync block
//   signal_detect     out  conditioned signal detect to sync block
//   link_status       out  1 = link up
//   rx_enable         out  receive path enabled
//   sudi_out[9:0]     out  gated SUDI, one cycle behind sudi_in
//   sudi_out_valid    out  qualifies sudi_out
//   link_state[2:0]   out  current FSM state encoding
//   link_loss_cnt     out  saturating link-loss event count
// ----------------------------------------------------------------------------
module pcs_rx_link_ctrl #(
    parameter int IDLE_MATCH     = 4,
    parameter int LINK_TIMER_MAX = 16,
    parameter int HOLDOFF_CYCLES = 8,
    parameter int LOSS_CNT_W     = 8
) (
    input  logic                  clock,
    input  logic                  mr_main_reset,
    input  logic                  signal_detect_in,
    input  logic                  mr_loopback,
    input  logic                  mr_restart,
    input  logic                  code_sync_status,
    input  logic                  rx_even,
    input  logic [9:0]            sudi_in,
    output logic                  signal_detect,
    output logic                  link_status,
    output logic                  rx_enable,
    output logic [9:0]            sudi_out,
    output logic                  sudi_out_valid,
    output logic [2:0]            link_state,
    output logic [LOSS_CNT_W-1:0] link_loss_cnt
);

    // The same timer serves LINK_TIMER and HOLDOFF, so it must fit both.
    localparam int LT_W  = $clog2(LINK_TIMER_MAX + 1);
    localparam int HO_W  = $clog2(HOLDOFF_CYCLES + 1);
    localparam int TMR_W = (LT_W > HO_W) ? LT_W : HO_W;
    localparam int IDL_W = $clog2(IDLE_MATCH + 1);

    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] LT_LAST  = TMR_W'(LINK_TIMER_MAX - 1);
    localparam logic [TMR_W-1:0] HO_LAST  = TMR_W'(HOLDOFF_CYCLES - 1);
    localparam logic [IDL_W-1:0] IDL_ZERO = {IDL_W{1'b0}};
    localparam logic [IDL_W-1:0] IDL_ONE  = IDL_W'(1);
    localparam logic [IDL_W-1:0] IDL_LAST = IDL_W'(IDLE_MATCH - 1);

    typedef enum logic [2:0] {
        ST_DISABLED   = 3'd0,
        ST_WAIT_SYNC  = 3'd1,
        ST_IDLE_CHECK = 3'd2,
        ST_LINK_TIMER = 3'd3,
        ST_LINK_UP    = 3'd4,
        ST_HOLDOFF    = 3'd5
    } state_t;

    // K28.5 in either running disparity.
    function automatic logic is_k28_5(input logic [9:0] cg);
        return (cg == 10'b0011111010) || (cg == 10'b1100000101);
    endfunction

    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic [IDL_W-1:0] r_idle_cnt;
    logic             r_signal_detect;
    logic             r_link_status;
    logic             r_rx_enable;
    logic [9:0]       r_sudi_out;
    logic             r_sudi_out_valid;

    state_t           w_next_state;
    logic [TMR_W-1:0] w_next_timer;
    logic [IDL_W-1:0] w_next_idle_cnt;
    logic             w_sig_ok;
    logic             w_k28_5;

    assign w_sig_ok = signal_detect_in | mr_loopback;
    assign w_k28_5  = is_k28_5(sudi_in);

    // Next-state, timer and idle-run counter decode.
    always_comb begin
        w_next_state    = r_state;
        w_next_timer    = TMR_ZERO;
        w_next_idle_cnt = IDL_ZERO;
        if (!w_sig_ok) begin
            w_next_state = ST_DISABLED;
        end else if (mr_restart && (r_state != ST_DISABLED)) begin
            // Holding restart keeps the holdoff timer at zero.
            w_next_state = ST_HOLDOFF;
        end else begin
            case (r_state)
                ST_DISABLED: begin
                    w_next_state = ST_WAIT_SYNC;
                end
                ST_WAIT_SYNC: begin
                    if (code_sync_status) begin
                        w_next_state = ST_IDLE_CHECK;
                    end else begin
                        w_next_state = ST_WAIT_SYNC;
                    end
                end
                ST_IDLE_CHECK: begin
                    w_next_idle_cnt = r_idle_cnt;
                    if (!code_sync_status) begin
                        w_next_state = ST_WAIT_SYNC;
                    end else if (rx_even) begin
                        if (!w_k28_5) begin
                            w_next_idle_cnt = IDL_ZERO;
                        end else if (r_idle_cnt == IDL_LAST) begin
                            // This K28.5 completes the run.
                            w_next_state    = ST_LINK_TIMER;
                            w_next_idle_cnt = IDL_ZERO;
                        end else begin
                            w_next_idle_cnt = r_idle_cnt + IDL_ONE;
                        end
                    end else begin
                        w_next_idle_cnt = r_idle_cnt;
                    end
                end
                ST_LINK_TIMER: begin
                    if (!code_sync_status) begin
                        w_next_state = ST_WAIT_SYNC;
                    end else if (r_timer == LT_LAST) begin
                        w_next_state = ST_LINK_UP;
                    end else begin
                        w_next_timer = r_timer + TMR_ONE;
                    end
                end
                ST_LINK_UP: begin
                    if (!code_sync_status) begin
                        w_next_state = ST_HOLDOFF;
                    end else begin
                        w_next_state = ST_LINK_UP;
                    end
                end
                ST_HOLDOFF: begin
                    if (r_timer == HO_LAST) begin
                        w_next_state = ST_WAIT_SYNC;
                    end else begin
                        w_next_timer = r_timer + TMR_ONE;
                    end
                end
                default: begin
                    w_next_state = ST_DISABLED;
                end
            endcase
        end
    end

    // State, counters and registered outputs. Status outputs are decoded
    // from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_state          <= ST_DISABLED;
            r_timer          <= TMR_ZERO;
            r_idle_cnt       <= IDL_ZERO;
            r_signal_detect  <= 1'b0;
            r_link_status    <= 1'b0;
            r_rx_enable      <= 1'b0;
            r_sudi_out       <= 10'd0;
            r_sudi_out_valid <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_timer          <= w_next_timer;
            r_idle_cnt       <= w_next_idle_cnt;
            r_signal_detect  <= (w_next_state != ST_DISABLED);
            r_link_status    <= (w_next_state == ST_LINK_UP);
            r_rx_enable      <= (w_next_state == ST_LINK_UP);
            r_sudi_out       <= r_rx_enable ? sudi_in : 10'd0;
            r_sudi_out_valid <= r_rx_enable;
        end
    end

`ifdef LINK_LOSS_CNT_EN
    logic                  w_loss_evt;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    // Leaving LINK_UP for any reason except a restart is a loss.
    assign w_loss_evt = (r_state == ST_LINK_UP) &&
                        (!w_sig_ok || (!mr_restart && !code_sync_status));

    // Saturating link-loss counter, cleared only by reset.
    always_ff @(posedge clock or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            r_loss_cnt <= {LOSS_CNT_W{1'b0}};
        end else if (w_loss_evt && (r_loss_cnt != {LOSS_CNT_W{1'b1}})) begin
            r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
        end else begin
            r_loss_cnt <= r_loss_cnt;
        end
    end

    assign link_loss_cnt = r_loss_cnt;
`else
    assign link_loss_cnt = {LOSS_CNT_W{1'b0}};
`endif

    assign signal_detect  = r_signal_detect;
    assign link_status    = r_link_status;
    assign rx_enable      = r_rx_enable;
    assign sudi_out       = r_sudi_out;
    assign sudi_out_valid = r_sudi_out_valid;
    assign link_state     = r_state;

endmodule

// File: tb/tb_pcs_rx_link_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pcs_rx_link_ctrl
//
// Directed bench for pcs_rx_link_ctrl. Bring-up, broken idle run, sync loss,
// loopback, restart, simultaneous loss and mid-link reset are walked through
// in a single linear sequence. Expected latencies are hand-derived.
// ----------------------------------------------------------------------------
module tb_pcs_rx_link_ctrl;

    localparam logic [9:0] K_NEG = 10'b1100000101;
    localparam logic [9:0] K_POS = 10'b0011111010;
    localparam logic [9:0] D_ODD = 10'b1010010110;

    logic       clock = 1'b0;
    logic       mr_main_reset;
    logic       signal_detect_in;
    logic       mr_loopback;
    logic       mr_restart;
    logic       code_sync_status;
    logic       rx_even;
    logic [9:0] sudi_in;
    logic       signal_detect;
    logic       link_status;
    logic       rx_enable;
    logic [9:0] sudi_out;
    logic       sudi_out_valid;
    logic [2:0] link_state;
    logic [7:0] link_loss_cnt;

    int         n_chk    = 0;
    int         n_fail   = 0;
    int         exp_loss = 0;
    logic       auto_pat = 1'b0;
    logic [9:0] pat_even = K_NEG;
    logic [9:0] prev_sudi;
    int         n;

    always #5 clock = ~clock;

    pcs_rx_link_ctrl dut (
        .clock            (clock),
        .mr_main_reset    (mr_main_reset),
        .signal_detect_in (signal_detect_in),
        .mr_loopback      (mr_loopback),
        .mr_restart       (mr_restart),
        .code_sync_status (code_sync_status),
        .rx_even          (rx_even),
        .sudi_in          (sudi_in),
        .signal_detect    (signal_detect),
        .link_status      (link_status),
        .rx_enable        (rx_enable),
        .sudi_out         (sudi_out),
        .sudi_out_valid   (sudi_out_valid),
        .link_state       (link_state),
        .link_loss_cnt    (link_loss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef LINK_LOSS_CNT_EN
        return 32'(exp_loss);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] all_outs();
        return {15'd0, link_state, signal_detect, link_status, rx_enable,
                sudi_out_valid, sudi_out};
    endfunction

    // One clock; returns on the falling edge, then advances the idle pattern.
    task automatic cyc();
        @(negedge clock);
        if (auto_pat) begin
            rx_even = ~rx_even;
            sudi_in = rx_even ? pat_even : D_ODD;
        end
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int max, output int cnt);
        cnt = 0;
        while ((link_state !== tgt) && (cnt < max)) begin
            cyc();
            cnt++;
        end
    endtask

    // From an observed WAIT_SYNC with sync held: full qualification to LINK_UP.
    task automatic bring_up();
        int c;
        rx_even = 1'b0;
        sudi_in = D_ODD;
        cyc();
        chk("bu_idle_check", 32'(link_state), 32'd2);
        wait_state(3'd3, 40, c);
        chk("bu_idle_cycles", 32'(c), 32'd7);
        wait_state(3'd4, 40, c);
        chk("bu_timer_cycles", 32'(c), 32'd16);
        chk("bu_link_status", 32'(link_status), 32'd1);
        chk("bu_rx_enable", 32'(rx_enable), 32'd1);
    endtask

    initial begin
        mr_main_reset    = 1'b0;
        signal_detect_in = 1'b0;
        mr_loopback      = 1'b0;
        mr_restart       = 1'b0;
        code_sync_status = 1'b0;
        rx_even          = 1'b0;
        sudi_in          = 10'd0;

        // 1: reset, then no signal for 20 cycles
        cyc();
        cyc();
        chk("reset_outs", all_outs(), 32'd0);
        mr_main_reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("no_signal_outs", all_outs(), 32'd0);
        end
        chk("no_signal_loss", 32'(link_loss_cnt), 32'd0);

        // 2: normal bring-up with alternating K28.5 / data
        signal_detect_in = 1'b1;
        auto_pat         = 1'b1;
        cyc();
        chk("up_wait_sync", 32'(link_state), 32'd1);
        chk("up_signal_detect", 32'(signal_detect), 32'd1);
        code_sync_status = 1'b1;
        bring_up();
        chk("up_valid_first", 32'(sudi_out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            prev_sudi = sudi_in;
            cyc();
            chk("up_sudi_track", 32'(sudi_out), 32'(prev_sudi));
            chk("up_sudi_valid", 32'(sudi_out_valid), 32'd1);
        end

        // 4: one-cycle sync drop in LINK_UP
        code_sync_status = 1'b0;
        cyc();
        exp_loss++;
        code_sync_status = 1'b1;
        chk("drop_state", 32'(link_state), 32'd5);
        chk("drop_link_status", 32'(link_status), 32'd0);
        chk("drop_rx_enable", 32'(rx_enable), 32'd0);
        chk("drop_loss_cnt", 32'(link_loss_cnt), exp_cnt());
        wait_state(3'd1, 40, n);
        chk("holdoff_cycles", 32'(n), 32'd8);
        chk("holdoff_valid", 32'(sudi_out_valid), 32'd0);
        chk("holdoff_sudi", 32'(sudi_out), 32'd0);

        // 3: idle run broken after 3 K28.5s by an even-position 1111111111
        pat_even = K_POS;
        rx_even  = 1'b0;
        sudi_in  = D_ODD;
        cyc();
        chk("brk_idle_check", 32'(link_state), 32'd2);
        for (int i = 0; i < 5; i++) cyc();
        pat_even = 10'h3FF;
        cyc();
        pat_even = K_POS;
        cyc();
        chk("brk_still_idle", 32'(link_state), 32'd2);
        wait_state(3'd3, 40, n);
        chk("brk_fresh_run", 32'(n), 32'd8);
        wait_state(3'd4, 40, n);
        chk("brk_timer_cycles", 32'(n), 32'd16);

        // 5: signal loss in LINK_UP, then loopback bring-up and loopback off
        signal_detect_in = 1'b0;
        cyc();
        exp_loss++;
        chk("los_state", 32'(link_state), 32'd0);
        chk("los_signal_detect", 32'(signal_detect), 32'd0);
        chk("los_loss_cnt", 32'(link_loss_cnt), exp_cnt());
        mr_loopback = 1'b1;
        cyc();
        chk("lpbk_wait_sync", 32'(link_state), 32'd1);
        chk("lpbk_signal_detect", 32'(signal_detect), 32'd1);
        bring_up();
        mr_loopback = 1'b0;
        cyc();
        exp_loss++;
        chk("lpbk_off_state", 32'(link_state), 32'd0);
        chk("lpbk_off_link", 32'(link_status), 32'd0);
        chk("lpbk_off_loss_cnt", 32'(link_loss_cnt), exp_cnt());

        // 6: restart during LINK_TIMER is not a loss
        signal_detect_in = 1'b1;
        cyc();
        chk("rst_wait_sync", 32'(link_state), 32'd1);
        rx_even = 1'b0;
        sudi_in = D_ODD;
        cyc();
        wait_state(3'd3, 40, n);
        chk("rst_idle_cycles", 32'(n), 32'd7);
        cyc();
        cyc();
        chk("rst_in_timer", 32'(link_state), 32'd3);
        mr_restart = 1'b1;
        cyc();
        mr_restart = 1'b0;
        chk("restart_holdoff", 32'(link_state), 32'd5);
        chk("restart_loss_cnt", 32'(link_loss_cnt), exp_cnt());
        wait_state(3'd1, 40, n);
        chk("restart_holdoff_cycles", 32'(n), 32'd8);

        // Simultaneous signal loss and sync loss in LINK_UP
        bring_up();
        signal_detect_in = 1'b0;
        code_sync_status = 1'b0;
        cyc();
        exp_loss++;
        chk("dual_state", 32'(link_state), 32'd0);
        chk("dual_loss_cnt", 32'(link_loss_cnt), exp_cnt());

        // Reset asserted mid-LINK_UP clears everything at once
        signal_detect_in = 1'b1;
        code_sync_status = 1'b1;
        cyc();
        bring_up();
        cyc();
        cyc();
        chk("pre_reset_valid", 32'(sudi_out_valid), 32'd1);
        #2;
        mr_main_reset = 1'b0;
        #1;
        chk("async_reset_outs", all_outs(), 32'd0);
        chk("async_reset_loss", 32'(link_loss_cnt), 32'd0);
        cyc();
        chk("held_reset_outs", all_outs(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
